// File: rtl/fsrc_input_feeder_if.sv
// Producer-side valid/ready stream carrying sfix13_En9 samples into the feeder.
interface fsrc_input_feeder_if;
    logic [12:0] data;
    logic        valid;
    logic        ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fsrc_input_feeder.sv
// Rate-pacing FIFO in front of the fractional SRC: absorbs a bursty producer and
// emits exactly one sample (or a zero filler) every RATIO enabled cycles.
module fsrc_input_feeder #(
    parameter int DEPTH   = 16,
    parameter int RATIO   = 13,
    parameter int PREFILL = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clk_enable,
    input  logic                     clear_flags,
    fsrc_input_feeder_if.slave       feed,
    output logic [12:0]              out_sample,
    output logic                     out_strobe,
    output logic                     underrun,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int PW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [LW-1:0] DEPTH_L   = LW'(DEPTH);
    localparam logic [LW-1:0] PREFILL_L = LW'(PREFILL);
    localparam logic [PW-1:0] PH_LAST   = PW'(RATIO - 1);

    typedef enum logic {PRIME, RUN} state_t;

    state_t          state, state_nxt;
    logic [PW-1:0]   phase;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [12:0]     mem [DEPTH];
    logic            push, pop_evt, rd_en, uflow;

    // No fall-through at full: a same-cycle pop does not open a slot.
    assign feed.ready = !reset && (level < DEPTH_L);
    assign push       = feed.valid && feed.ready && clk_enable;
    assign pop_evt    = clk_enable && (phase == PH_LAST);

    always_ff @(posedge clk) begin
        if (reset) state <= PRIME;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        uflow     = 1'b0;
        unique case (state)
            PRIME: if (clk_enable && level >= PREFILL_L) state_nxt = RUN;
            RUN: begin
                if (pop_evt) begin
                    if (level != '0) begin
                        rd_en = 1'b1;
                    end else begin
                        uflow     = 1'b1;
                        state_nxt = PRIME;
                    end
                end
            end
            default: state_nxt = PRIME;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= feed.data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            phase      <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            out_sample <= '0;
            out_strobe <= 1'b0;
            underrun   <= 1'b0;
        end else if (clk_enable) begin
            phase      <= pop_evt ? '0 : phase + PW'(1);
            out_strobe <= pop_evt;
            // Filler zero on every pop that does not read the FIFO (PRIME or empty).
            if (pop_evt) out_sample <= rd_en ? mem[rd_ptr] : 13'd0;
            if (push)    wr_ptr <= wr_ptr + AW'(1);
            if (rd_en)   rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, rd_en})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            underrun <= uflow | (underrun & ~clear_flags);
        end else begin
            out_strobe <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fsrc_input_feeder.sv
// Directed bench for fsrc_input_feeder with a queue-based scoreboard model.
module tb_fsrc_input_feeder;
    localparam int DEPTH   = 16;
    localparam int RATIO   = 13;
    localparam int PREFILL = 4;

    logic        clk = 1'b0;
    logic        reset, clk_enable, clear_flags;
    logic [12:0] out_sample;
    logic        out_strobe, underrun;
    logic [4:0]  level;

    fsrc_input_feeder_if f();

    fsrc_input_feeder #(.DEPTH(DEPTH), .RATIO(RATIO), .PREFILL(PREFILL)) dut (
        .clk(clk), .reset(reset), .clk_enable(clk_enable), .clear_flags(clear_flags),
        .feed(f), .out_sample(out_sample), .out_strobe(out_strobe),
        .underrun(underrun), .level(level)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: samples queued as they are accepted, popped at pop events.
    logic [12:0] mq[$];
    int          m_phase = 0;
    bit          m_run = 0, m_strobe = 0, m_under = 0, model_on = 0;
    logic [12:0] m_out = '0;

    always @(posedge clk) begin
        int  pre;
        bit  pushed, pop, was_run, uf;
        if (reset) begin
            mq.delete();
            m_phase = 0; m_run = 0; m_out = '0; m_strobe = 0; m_under = 0;
            model_on = 1;
        end else if (clk_enable) begin
            pre     = mq.size();
            pushed  = f.valid && (pre < DEPTH);
            pop     = (m_phase == RATIO - 1);
            was_run = m_run;
            uf      = 0;
            m_strobe = pop;
            m_phase  = pop ? 0 : m_phase + 1;
            if (pop) begin
                if (was_run && pre > 0) m_out = mq.pop_front();
                else                    m_out = '0;
                if (was_run && pre == 0) begin
                    uf = 1; m_run = 0;
                end
            end
            if (!was_run && pre >= PREFILL) m_run = 1;
            if (pushed) mq.push_back(f.data);
            m_under = uf | (m_under & ~clear_flags);
        end else begin
            m_strobe = 0;
        end
    end

    always @(posedge clk) begin
        #2;
        if (model_on) begin
            chk("m_strobe",   out_strobe, m_strobe);
            chk("m_sample",   out_sample, m_out);
            chk("m_underrun", underrun,   m_under);
            chk("m_level",    level,      mq.size());
            chk("m_ready",    f.ready,    (!reset && mq.size() < DEPTH));
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_strobe();
        int k = 0;
        do begin @(negedge clk); k++; end while (!out_strobe && k < 40);
        chk("wait_strobe", out_strobe, 1);
    endtask

    task automatic wait_level_after_strobe(input int lv, input string tag);
        int k = 0;
        do begin @(negedge clk); k++; end while (!(out_strobe && level == lv) && k < 400);
        chk(tag, level, lv);
    endtask

    initial begin
        int  cnt, lv;
        bit  acc, saw_full;
        reset = 1; clk_enable = 1; clear_flags = 0; f.valid = 0; f.data = '0;
        step(3);
        chk("rst_sample", out_sample, 0);
        chk("rst_strobe", out_strobe, 0);
        chk("rst_level",  level, 0);
        chk("rst_ready",  f.ready, 0);
        reset = 0;
        #1 chk("ready_after_rst", f.ready, 1);

        // Idle PRIME: zero strobes on edges 13, 26, 39.
        step(12); chk("no_strobe_e12", out_strobe, 0);
        step(1);  chk("strobe_e13", out_strobe, 1); chk("zero_e13", out_sample, 0);
        step(13); chk("strobe_e26", out_strobe, 1);
        step(13); chk("strobe_e39", out_strobe, 1); chk("no_underrun_idle", underrun, 0);

        // Prime with four samples, stream them out, then underrun.
        for (int i = 1; i <= 4; i++) begin
            f.valid = 1; f.data = 13'(i); step(1);
        end
        f.valid = 0;
        chk("primed_level", level, 4);
        step(9);  chk("out1", out_sample, 13'h001);
        step(13); chk("out2", out_sample, 13'h002);
        step(13); chk("out3", out_sample, 13'h003);
        step(13); chk("out4", out_sample, 13'h004);
        step(13); chk("out5_zero", out_sample, 0); chk("underrun_set", underrun, 1);
        clear_flags = 1; step(1); clear_flags = 0;
        chk("underrun_clr", underrun, 0);

        // Backpressure with an incrementing counter.
        cnt = 0; saw_full = 0;
        for (int i = 0; i < 90; i++) begin
            f.valid = 1; f.data = 13'h100 + 13'(cnt);
            acc = f.ready;
            step(1);
            if (acc) cnt++;
            if (level == 16) begin
                saw_full = 1;
                chk("full_ready_low", f.ready, 0);
            end
        end
        f.valid = 0;
        chk("saw_full", saw_full, 1);

        // Push on the pop edge at level 5.
        wait_level_after_strobe(5, "reach_l5");
        step(12); f.valid = 1; f.data = 13'h0A5; step(1); f.valid = 0;
        chk("simul_strobe", out_strobe, 1);
        chk("simul_level5", level, 5);

        // Push into empty FIFO on a pop edge in RUN: no bypass.
        wait_level_after_strobe(0, "reach_l0");
        chk("pre_empty_underrun", underrun, 0);
        step(12); f.valid = 1; f.data = 13'h0B6; step(1); f.valid = 0;
        chk("empty_pop_zero", out_sample, 0);
        chk("empty_pop_underrun", underrun, 1);
        chk("empty_pop_level", level, 1);
        clear_flags = 1; step(1); clear_flags = 0;

        // clk_enable low for 7 cycles at phase 6.
        wait_strobe();
        step(6);
        lv = level;
        clk_enable = 0; f.valid = 1; f.data = 13'h0C7;
        for (int i = 0; i < 7; i++) begin
            step(1);
            chk("gated_strobe", out_strobe, 0);
            chk("gated_level", level, lv);
        end
        clk_enable = 1; f.valid = 0;
        step(6); chk("delayed_no_strobe", out_strobe, 0);
        step(1); chk("delayed_strobe", out_strobe, 1);

        // Fill to 9, then reset mid-operation.
        cnt = 0;
        while (level < 9 && cnt < 60) begin
            f.valid = 1; f.data = 13'h1000 + 13'(cnt); cnt++; step(1);
        end
        f.valid = 0;
        chk("level9", level, 9);
        reset = 1; step(1); reset = 0;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_sample", out_sample, 0);
        chk("mid_rst_underrun", underrun, 0);

        // Set-wins on coincident clear, then clear alone.
        for (int i = 0; i < 4; i++) begin
            f.valid = 1; f.data = 13'h1F00 + 13'(i); step(1);
        end
        f.valid = 0;
        for (int i = 0; i < 4; i++) wait_strobe();
        chk("last_sample", out_sample, 13'h1F03);
        step(12); clear_flags = 1; step(1);
        chk("coinc_strobe", out_strobe, 1);
        chk("coinc_underrun", underrun, 1);
        step(1); clear_flags = 0;
        chk("clear_alone", underrun, 0);
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
